// File: rtl/ex_pkg.sv
// Shared widths, operation codes and divider state encoding for the MIPS32 execute stage.
package ex_pkg;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [AluOpBus-1:0] EXE_MOVZ_OP = 8'b00001010;
  localparam logic [AluOpBus-1:0] EXE_MOVN_OP = 8'b00001011;
  localparam logic [AluOpBus-1:0] EXE_MFHI_OP = 8'b00010000;
  localparam logic [AluOpBus-1:0] EXE_MTHI_OP = 8'b00010001;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP = 8'b00010010;
  localparam logic [AluOpBus-1:0] EXE_MTLO_OP = 8'b00010011;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [AluSelBus-1:0] EXE_RES_MOVE  = 3'b011;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, signs fixed up on the way out.
module ex_div
  import ex_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [RegBus-1:0]   opdata1_i,
  input  logic [RegBus-1:0]   opdata2_i,
  input  logic                start_i,
  output logic [2*RegBus-1:0] result_o,
  output logic                ready_o
);
  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [64:0] dividend_q;
  logic [31:0] divisor_q;
  logic        neg_quot_q;
  logic        neg_rem_q;

  logic [31:0] abs1, abs2, diff, quot, rem;
  logic        ge;

  always_comb begin
    abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    // Partial remainder is compared at 33 bits so divisors above 2^31 cannot overflow it.
    ge   = dividend_q[64:32] >= {1'b0, divisor_q};
    diff = 32'(dividend_q[64:32] - {1'b0, divisor_q});
    quot = neg_quot_q ? -dividend_q[31:0] : dividend_q[31:0];
    rem  = neg_rem_q ? -dividend_q[64:33] : dividend_q[64:33];
  end

  assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result_o = ready_o ? {rem, quot} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      case (state_q)
        DivFree: begin
          if (start_i) begin
            cnt_q      <= '0;
            divisor_q  <= abs2;
            neg_quot_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_q  <= signed_div_i & opdata1_i[31];
            if (opdata2_i == '0) begin
              state_q    <= DivByZero;
              dividend_q <= '0;
            end else begin
              state_q    <= DivOn;
              dividend_q <= {32'd0, abs1, 1'b0};
            end
          end
        end
        DivByZero: state_q <= DivEnd;
        DivOn: begin
          if (ge) dividend_q <= {diff, dividend_q[31:0], 1'b1};
          else    dividend_q <= {dividend_q[63:0], 1'b0};
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= DivEnd;
        end
        DivEnd:  state_q <= DivFree;
        default: state_q <= DivFree;
      endcase
    end
  end
endmodule

// File: rtl/ex.sv
// MIPS32 execute stage: logic/shift/move results, HI/LO write requests and a stalling divider.
module ex
  import ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [AluSelBus-1:0]  alusel_i,
  input  logic [RegBus-1:0]     reg1_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  input  logic                  mem_whilo_i,
  input  logic [RegBus-1:0]     mem_hi_i,
  input  logic [RegBus-1:0]     mem_lo_i,
  input  logic                  wb_whilo_i,
  input  logic [RegBus-1:0]     wb_hi_i,
  input  logic [RegBus-1:0]     wb_lo_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic                  stallreq_o
);
  logic [RegBus-1:0]   hi_cur, lo_cur, logic_res, shift_res, move_res;
  logic [2*RegBus-1:0] div_result;
  logic                is_div, div_ready;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  ex_div u_div (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (aluop_i == EXE_DIV_OP),
    .opdata1_i    (reg1_i),
    .opdata2_i    (reg2_i),
    .start_i      (is_div),
    .result_o     (div_result),
    .ready_o      (div_ready)
  );

  always_comb begin
    // Youngest in-flight HI/LO write wins over the architectural copy.
    if (mem_whilo_i)     {hi_cur, lo_cur} = {mem_hi_i, mem_lo_i};
    else if (wb_whilo_i) {hi_cur, lo_cur} = {wb_hi_i, wb_lo_i};
    else                 {hi_cur, lo_cur} = {hi_i, lo_i};

    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase

    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = '0;
    endcase

    case (aluop_i)
      EXE_MFHI_OP:             move_res = hi_cur;
      EXE_MFLO_OP:             move_res = lo_cur;
      EXE_MOVN_OP, EXE_MOVZ_OP: move_res = reg1_i;
      default:                 move_res = '0;
    endcase
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      stallreq_o = is_div && !div_ready;
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        EXE_RES_MOVE:  wdata_o = move_res;
        default:       wdata_o = '0;
      endcase
      if (aluop_i == EXE_MTHI_OP) begin
        whilo_o = 1'b1;
        hi_o    = reg1_i;
        lo_o    = lo_cur;
      end else if (aluop_i == EXE_MTLO_OP) begin
        whilo_o = 1'b1;
        hi_o    = hi_cur;
        lo_o    = reg1_i;
      end else if (is_div && div_ready) begin
        whilo_o       = 1'b1;
        {hi_o, lo_o}  = div_result;
      end
    end
  end
endmodule
